// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester IDs.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } arbState_e;

    typedef logic reqId_t;

    localparam reqId_t ID_CPU = 1'b0;
    localparam reqId_t ID_IO  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and dmemory32.
interface dmem_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;

    logic        io_req;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_gnt;
    logic        io_rvalid;

    logic [31:0] rdata;

    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, rdata,
        output mem_write, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, rdata,
        input  mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way combinational winner select: round-robin on ties, or fixed CPU priority.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic   cpuReq,
    input  logic   ioReq,
    input  reqId_t lastId,
    input  logic   cpuPrio,
    output reqId_t winId,
    output logic   winValid
);

    always_comb begin
        winValid = cpuReq | ioReq;
        winId    = ID_CPU;
        if (cpuReq && ioReq) begin
            // On a tie the requester not served last wins unless CPU priority is set
            winId = (cpuPrio || (lastId == ID_IO)) ? ID_CPU : ID_IO;
        end else if (ioReq) begin
            winId = ID_IO;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and IO-loader accesses onto a single synchronous-read dmemory32 port.
//
// state   | meaning
// IDLE    | arbitrate; winner's gnt pulses and its request is latched
// WR      | mem_write=1 with latched addr/wdata for one cycle
// RD_ADDR | latched addr presented to memory
// RD_DATA | mem_rdata captured into rdata; owner's rvalid pulses next cycle
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    arbState_e   state;
    reqId_t      lastServed;
    reqId_t      owner;
    reqId_t      winId;
    logic        winValid;
    logic        grant;

    logic        winWe;
    logic [31:0] winAddr;
    logic [31:0] winWdata;

    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] rdataQ;
    logic        cpuRvalid;
    logic        ioRvalid;

    arb_rr2 uArb (
        .cpuReq   (bus.cpu_req),
        .ioReq    (bus.io_req),
        .lastId   (lastServed),
        .cpuPrio  (CPU_PRIO),
        .winId    (winId),
        .winValid (winValid)
    );

    // Grant is a same-cycle pulse, so it must be masked while reset is held
    assign grant    = (state == IDLE) && winValid && !reset;
    assign winWe    = (winId == ID_CPU) ? bus.cpu_we    : bus.io_we;
    assign winAddr  = (winId == ID_CPU) ? bus.cpu_addr  : bus.io_addr;
    assign winWdata = (winId == ID_CPU) ? bus.cpu_wdata : bus.io_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lastServed <= ID_IO;
            owner      <= ID_CPU;
            memWrite   <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            rdataQ     <= '0;
            cpuRvalid  <= 1'b0;
            ioRvalid   <= 1'b0;
        end else begin
            cpuRvalid <= 1'b0;
            ioRvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        lastServed <= winId;
                        owner      <= winId;
                        memAddr    <= winAddr;
                        memWdata   <= winWdata;
                        if (winWe) begin
                            memWrite <= 1'b1;
                            state    <= WR;
                        end else begin
                            state    <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    memWrite <= 1'b0;
                    memAddr  <= '0;
                    memWdata <= '0;
                    state    <= IDLE;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    rdataQ    <= bus.mem_rdata;
                    cpuRvalid <= (owner == ID_CPU);
                    ioRvalid  <= (owner == ID_IO);
                    memAddr   <= '0;
                    memWdata  <= '0;
                    state     <= IDLE;
                end
                default: begin
                    memWrite <= 1'b0;
                    memAddr  <= '0;
                    memWdata <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_gnt    = grant && (winId == ID_CPU);
    assign bus.io_gnt     = grant && (winId == ID_IO);
    assign bus.cpu_rvalid = cpuRvalid;
    assign bus.io_rvalid  = ioRvalid;
    assign bus.rdata      = rdataQ;
    assign bus.mem_write  = memWrite;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin arbiter (dut0) with a dmemory32 model, plus a CPU-priority copy (dut1).
module tb_dmem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clock = ~clock;

    dmem_arbiter_if bus0 ();
    dmem_arbiter_if bus1 ();

    dmem_arbiter #(.CPU_PRIO(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    dmem_arbiter #(.CPU_PRIO(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    // Synchronous-read memory: data appears one cycle after the address
    logic [31:0] mem0 [0:255];
    always @(posedge clock) begin
        if (bus0.mem_write) mem0[bus0.mem_addr[9:2]] <= bus0.mem_wdata;
        bus0.mem_rdata <= mem0[bus0.mem_addr[9:2]];
    end

    typedef struct {
        logic        cReq, cWe;
        logic [31:0] cAddr, cWdata;
        logic        iReq, iWe;
        logic [31:0] iAddr, iWdata;
        logic        eCGnt, eIGnt, eCRv, eIRv, eMw;
        logic [31:0] eAddr, eWdata, eRdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(
        logic cReq, logic cWe, logic [31:0] cAddr, logic [31:0] cWdata,
        logic iReq, logic iWe, logic [31:0] iAddr, logic [31:0] iWdata,
        logic eCGnt, logic eIGnt, logic eCRv, logic eIRv, logic eMw,
        logic [31:0] eAddr, logic [31:0] eWdata, logic [31:0] eRdata);
        vec_t v;
        v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr; v.cWdata = cWdata;
        v.iReq = iReq; v.iWe = iWe; v.iAddr = iAddr; v.iWdata = iWdata;
        v.eCGnt = eCGnt; v.eIGnt = eIGnt; v.eCRv = eCRv; v.eIRv = eIRv; v.eMw = eMw;
        v.eAddr = eAddr; v.eWdata = eWdata; v.eRdata = eRdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive0(input vec_t v);
        bus0.cpu_req = v.cReq; bus0.cpu_we = v.cWe; bus0.cpu_addr = v.cAddr; bus0.cpu_wdata = v.cWdata;
        bus0.io_req  = v.iReq; bus0.io_we  = v.iWe; bus0.io_addr  = v.iAddr; bus0.io_wdata  = v.iWdata;
    endtask

    task automatic drive1(input vec_t v);
        bus1.cpu_req = v.cReq; bus1.cpu_we = v.cWe; bus1.cpu_addr = v.cAddr; bus1.cpu_wdata = v.cWdata;
        bus1.io_req  = v.iReq; bus1.io_we  = v.iWe; bus1.io_addr  = v.iAddr; bus1.io_wdata  = v.iWdata;
    endtask

    task automatic check0(input string tag, input vec_t v);
        chk({tag, " cpu_gnt"},    {31'd0, bus0.cpu_gnt},    {31'd0, v.eCGnt});
        chk({tag, " io_gnt"},     {31'd0, bus0.io_gnt},     {31'd0, v.eIGnt});
        chk({tag, " cpu_rvalid"}, {31'd0, bus0.cpu_rvalid}, {31'd0, v.eCRv});
        chk({tag, " io_rvalid"},  {31'd0, bus0.io_rvalid},  {31'd0, v.eIRv});
        chk({tag, " mem_write"},  {31'd0, bus0.mem_write},  {31'd0, v.eMw});
        chk({tag, " mem_addr"},   bus0.mem_addr,  v.eAddr);
        chk({tag, " mem_wdata"},  bus0.mem_wdata, v.eWdata);
        chk({tag, " rdata"},      bus0.rdata,     v.eRdata);
    endtask

    initial begin
        vec_t idle, tie, v;
        logic [31:0] rdRef;
        rdRef = 32'ha00000f5;
        idle  = mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0);
        tie   = mkVec(1,1,32'h40,32'h1, 1,1,32'h44,32'h2, 0,0,0,0,0, 0,0,0);

        for (int i = 0; i < 256; i++) mem0[i] = 32'h0;
        bus0.mem_rdata = 32'h0;
        bus1.mem_rdata = 32'h0;
        drive1(idle);
        // Requests held during reset must not produce a grant
        drive0(tie);

        // cpu write, then cpu read-back of the same word
        vecs.push_back(mkVec(1,1,32'h10,32'ha00000f5, 0,0,0,0, 1,0,0,0,0, 0,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0,1, 32'h10,32'ha00000f5,0));
        vecs.push_back(mkVec(1,0,32'h10,0, 0,0,0,0, 1,0,0,0,0, 0,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 32'h10,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 32'h10,0,0));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0,1,0,0, 0,0,rdRef));
        // io write 0x20, then io read 0x10 with io_addr changed after gnt
        vecs.push_back(mkVec(0,0,0,0, 1,1,32'h20,32'h12345678, 0,1,0,0,0, 0,0,rdRef));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0,1, 32'h20,32'h12345678,rdRef));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h10,0, 0,1,0,0,0, 0,0,rdRef));
        vecs.push_back(mkVec(0,0,0,0, 1,0,32'h20,0, 0,0,0,0,0, 32'h10,0,rdRef));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 32'h10,0,rdRef));
        // ties: last served IO -> CPU, then IO, then CPU
        vecs.push_back(mkVec(1,1,32'h40,32'h1, 1,1,32'h44,32'h2, 1,0,0,1,0, 0,0,rdRef));
        vecs.push_back(mkVec(1,1,32'h40,32'h1, 1,1,32'h44,32'h2, 0,0,0,0,1, 32'h40,32'h1,rdRef));
        vecs.push_back(mkVec(1,1,32'h40,32'h1, 1,1,32'h44,32'h2, 0,1,0,0,0, 0,0,rdRef));
        vecs.push_back(mkVec(1,1,32'h40,32'h1, 1,1,32'h44,32'h2, 0,0,0,0,1, 32'h44,32'h2,rdRef));
        vecs.push_back(mkVec(1,1,32'h40,32'h1, 1,1,32'h44,32'h2, 1,0,0,0,0, 0,0,rdRef));
        vecs.push_back(mkVec(1,1,32'h40,32'h1, 1,1,32'h44,32'h2, 0,0,0,0,1, 32'h40,32'h1,rdRef));
        vecs.push_back(mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,rdRef));

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check0("reset", idle);
        chk("reset dut1 cpu_gnt", {31'd0, bus1.cpu_gnt}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive0(idle);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            drive0(vecs[i]);
            @(negedge clock);
            check0($sformatf("v%0d", i), vecs[i]);
        end

        // Both requesters held: dut0 alternates starting with IO (CPU served last), dut1 always CPU
        for (int k = 0; k < 16; k++) begin
            logic gIo;
            @(posedge clock);
            #1;
            drive0(tie);
            drive1(tie);
            @(negedge clock);
            gIo = ((k / 2) % 2) == 0;
            v = idle;
            v.eRdata = rdRef;
            if (k % 2 == 0) begin
                v.eCGnt = !gIo;
                v.eIGnt = gIo;
            end else begin
                v.eMw    = 1'b1;
                v.eAddr  = gIo ? 32'h44 : 32'h40;
                v.eWdata = gIo ? 32'h2  : 32'h1;
            end
            check0($sformatf("rr%0d", k), v);
            chk($sformatf("prio%0d cpu_gnt", k), {31'd0, bus1.cpu_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("prio%0d io_gnt", k),  {31'd0, bus1.io_gnt},  32'd0);
        end

        // Requests dropped before gnt: no access
        @(posedge clock);
        #1;
        drive0(idle);
        drive1(idle);
        @(negedge clock);
        v = idle;
        v.eRdata = rdRef;
        check0("drop", v);

        // CPU read, reset while in RD_ADDR aborts it
        @(posedge clock);
        #1;
        drive0(mkVec(1,0,32'h10,0, 0,0,0,0, 0,0,0,0,0, 0,0,0));
        @(negedge clock);
        chk("abort gnt", {31'd0, bus0.cpu_gnt}, 32'd1);
        @(posedge clock);
        #1;
        drive0(idle);
        reset = 1'b1;
        @(negedge clock);
        chk("abort rd_addr", bus0.mem_addr, 32'h10);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check0("after reset", idle);
        // Tie right after reset goes to CPU; the aborted read never returns rvalid
        @(posedge clock);
        #1;
        drive0(tie);
        @(negedge clock);
        v = idle;
        v.eCGnt = 1'b1;
        check0("post tie", v);
        @(posedge clock);
        #1;
        drive0(idle);
        @(negedge clock);
        v = idle;
        v.eMw = 1'b1; v.eAddr = 32'h40; v.eWdata = 32'h1;
        check0("post wr", v);
        @(posedge clock);
        #1;
        @(negedge clock);
        check0("post idle", idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: CPU_PRIO, default 0, 0 = round-robin between requesters, 1 = CPU always wins ties.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU requests one data-memory access.
REQ-005 cpu_we  input  1  CPU access type: 1 = write, 0 = read.
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_gnt  output  1  one-cycle pulse: CPU request accepted and latched.
REQ-009 cpu_rvalid  output  1  one-cycle pulse: rdata holds the CPU read result.
REQ-010 io_req  input  1  IO/UART-loader requests one data-memory access.
REQ-011 io_we  input  1  IO access type: 1 = write, 0 = read.
REQ-012 io_addr  input  32  IO byte address.
REQ-013 io_wdata  input  32  IO write data.
REQ-014 io_gnt  output  1  one-cycle pulse: IO request accepted and latched.
REQ-015 io_rvalid  output  1  one-cycle pulse: rdata holds the IO read result.
REQ-016 rdata  output  32  registered read data, shared by both requesters.
REQ-017 mem_write  output  1  write enable to dmemory32.
REQ-018 mem_addr  output  32  address to dmemory32.
REQ-019 mem_wdata  output  32  write data to dmemory32.
REQ-020 mem_rdata  input  32  read data from dmemory32, valid one cycle after mem_addr is presented.

Function
REQ-021 The FSM SHALL have states IDLE, WR, RD_ADDR and RD_DATA; arbitration SHALL occur only in IDLE.
REQ-022 In IDLE with any req high, the arbiter SHALL latch the winner's we/addr/wdata, pulse the winner's gnt in that cycle, and move to WR (we=1) or RD_ADDR (we=0).
REQ-023 WR SHALL drive mem_write=1 with the latched mem_addr/mem_wdata for exactly one cycle, then return to IDLE; a write occupies 2 cycles.
REQ-024 RD_ADDR SHALL drive the latched mem_addr with mem_write=0 and then go to RD_DATA.
REQ-025 RD_DATA SHALL register mem_rdata into rdata, pulse the owner's rvalid on the following cycle, and return to IDLE; a read occupies 3 cycles, with rvalid 3 cycles after gnt.
REQ-026 Tie handling: with CPU_PRIO=0 the requester not served last SHALL win; with CPU_PRIO=1 the CPU SHALL win.
REQ-027 A single active requester SHALL be served every transaction, with exactly one IDLE cycle between transactions.
REQ-028 Requester inputs SHALL be ignored after gnt; a req dropped before gnt SHALL cause no access.
REQ-029 mem_write SHALL be 0 in every state except WR; mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-030 rdata SHALL hold its value until the next completed read.
REQ-031 At most one gnt and at most one rvalid SHALL be high in any cycle.

Reset
REQ-032 On reset the arbiter SHALL enter IDLE, and every output (gnt, rvalid, mem_write, mem_addr, mem_wdata, rdata) SHALL be 0; the last-served register SHALL be IO, so the CPU wins the first tie.
REQ-033 A reset asserted mid-transaction SHALL abort it: no rvalid pulse, and mem_write=0 from the next edge.

Structure
REQ-034 The state encoding and the requester IDs (ID_CPU=0, ID_IO=1) SHALL live in package dmem_arb_pkg.
REQ-035 Winner selection SHALL be a combinational sub-module arb_rr2 (inputs: two reqs, last-served ID, CPU_PRIO; output: winner ID and valid); the FSM and datapath registers stay in dmem_arbiter.

Verification
REQ-036 CPU write, cpu_addr=0x10, cpu_wdata=0xa00000f5 -> cpu_gnt at cycle 0; mem_write=1 with mem_addr=0x10 and mem_wdata=0xa00000f5 at cycle 1.
REQ-037 Then CPU read, cpu_addr=0x10 -> cpu_rvalid pulses at cycle 3 with rdata=0xa00000f5, and io_rvalid stays 0.
REQ-038 cpu_req and io_req held high for 8 transactions with CPU_PRIO=0 -> grants alternate CPU, IO, CPU, IO...; with CPU_PRIO=1 -> all grants go to CPU.
REQ-039 IO read granted, then io_addr changed to 0x20 in the next cycle -> mem_addr stays at the latched address and rdata returns the original location.
REQ-040 reset asserted in RD_ADDR -> no rvalid, all outputs 0 next cycle, and the next tie is granted to CPU.
